// File: rtl/uart_pkg.sv
// Shared UART FIFO controller types and default parameters.
package uart_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_DATA_W = 8;
  localparam int TXD_W      = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers and flush.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_drop,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_hold;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [WIDTH-1:0] w_head;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign w_pop_ok  = i_pop && !o_empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
  assign w_push_ok = i_push && (!o_full || i_pop) && !i_flush;
  assign o_drop    = i_push && o_full && !i_pop && !i_flush;
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign o_rdata   = o_empty ? r_hold : w_head;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_hold   <= '0;
    end else begin
      if (!o_empty) r_hold <= w_head;
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART host-side controller: TX/RX FIFOs, transmit launch FSM, RTS flow control.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RTS_THRESH = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tx_wr_i,
  input  logic [DATA_W-1:0]      tx_wdata_i,
  input  logic                   tx_flush_i,
  output logic                   tx_full_o,
  output logic                   tx_empty_o,
  output logic [$clog2(DEPTH):0] tx_level_o,
  output logic                   tx_ovf_o,
  output logic                   start_tx_o,
  output logic [TXD_W-1:0]       tx_data_o,
  input  logic                   tx_done_i,
  input  logic                   cts_n_i,
  input  logic                   rx_done_i,
  input  logic [31:0]            rx_data_i,
  input  logic                   parity_error_i,
  output logic                   host_read_data_o,
  output logic                   rts_n_o,
  input  logic                   rx_rd_i,
  input  logic                   rx_flush_i,
  output logic [DATA_W-1:0]      rx_rdata_o,
  output logic                   rx_perr_o,
  output logic                   rx_full_o,
  output logic                   rx_empty_o,
  output logic [$clog2(DEPTH):0] rx_level_o,
  output logic                   rx_ovr_o,
  input  logic                   err_clr_i
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] RTS_LVL = LW'(RTS_THRESH);

  tx_state_e         r_state;
  tx_state_e         w_next;
  logic              w_tx_pop;
  logic              w_tx_drop;
  logic [DATA_W-1:0] w_tx_head;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_cts_n;
  logic              r_tx_ovf;

  logic              r_rx_done_d;
  logic              w_rx_edge;
  logic              w_rx_drop;
  logic [DATA_W:0]   w_rx_head;
  logic              r_ack;
  logic              r_rts_n;
  logic              r_rx_ovr;
  logic              w_unused_rx;

  assign w_unused_rx = ^rx_data_i[31:DATA_W];

  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (tx_wr_i),
    .i_pop   (w_tx_pop),
    .i_flush (tx_flush_i),
    .i_wdata (tx_wdata_i),
    .o_rdata (w_tx_head),
    .o_full  (tx_full_o),
    .o_empty (tx_empty_o),
    .o_drop  (w_tx_drop),
    .o_level (tx_level_o)
  );

  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W + 1)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_edge),
    .i_pop   (rx_rd_i),
    .i_flush (rx_flush_i),
    .i_wdata ({parity_error_i, rx_data_i[DATA_W-1:0]}),
    .o_rdata (w_rx_head),
    .o_full  (rx_full_o),
    .o_empty (rx_empty_o),
    .o_drop  (w_rx_drop),
    .o_level (rx_level_o)
  );

  // cts_n_i comes from the peer's pin, so it is retimed once before use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cts_n   <= 1'b1;
      r_tx_data <= '0;
      r_tx_ovf  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cts_n <= cts_n_i;
      if (w_tx_pop)       r_tx_data <= w_tx_head;
      if (w_tx_drop)      r_tx_ovf  <= 1'b1;
      else if (err_clr_i) r_tx_ovf  <= 1'b0;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_tx_pop = 1'b0;
    case (r_state)
      IDLE: begin
        if (!tx_empty_o && !r_cts_n) begin
          w_next   = LAUNCH;
          w_tx_pop = 1'b1;
        end
      end
      LAUNCH:    w_next = WAIT_DONE;
      WAIT_DONE: if (tx_done_i) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_done_d <= 1'b0;
      r_ack       <= 1'b0;
      r_rts_n     <= 1'b0;
      r_rx_ovr    <= 1'b0;
    end else begin
      r_rx_done_d <= rx_done_i;
      r_ack       <= w_rx_edge;
      r_rts_n     <= (rx_level_o >= RTS_LVL);
      if (w_rx_drop)      r_rx_ovr <= 1'b1;
      else if (err_clr_i) r_rx_ovr <= 1'b0;
    end
  end

  assign w_rx_edge        = rx_done_i && !r_rx_done_d;
  assign start_tx_o       = (r_state == LAUNCH);
  assign tx_data_o        = {{(TXD_W - DATA_W){1'b0}}, r_tx_data};
  assign tx_ovf_o         = r_tx_ovf;
  assign host_read_data_o = r_ack;
  assign rts_n_o          = r_rts_n;
  assign rx_rdata_o       = w_rx_head[DATA_W-1:0];
  assign rx_perr_o        = w_rx_head[DATA_W];
  assign rx_ovr_o         = r_rx_ovr;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench: queue-based reference model plus directed scenarios.
module tb_uart_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int TH    = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        tx_wr_i = 0, tx_flush_i = 0, tx_done_i = 0, cts_n_i = 1;
  logic [7:0]  tx_wdata_i = 0;
  logic        rx_done_i = 0, parity_error_i = 0, rx_rd_i = 0, rx_flush_i = 0, err_clr_i = 0;
  logic [31:0] rx_data_i = 0;
  logic        tx_full_o, tx_empty_o, tx_ovf_o, start_tx_o, host_read_data_o, rts_n_o;
  logic [4:0]  tx_level_o, rx_level_o;
  logic [31:0] tx_data_o;
  logic [7:0]  rx_rdata_o;
  logic        rx_perr_o, rx_full_o, rx_empty_o, rx_ovr_o;

  uart_fifo_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .tx_wr_i(tx_wr_i), .tx_wdata_i(tx_wdata_i),
    .tx_flush_i(tx_flush_i), .tx_full_o(tx_full_o), .tx_empty_o(tx_empty_o),
    .tx_level_o(tx_level_o), .tx_ovf_o(tx_ovf_o), .start_tx_o(start_tx_o),
    .tx_data_o(tx_data_o), .tx_done_i(tx_done_i), .cts_n_i(cts_n_i),
    .rx_done_i(rx_done_i), .rx_data_i(rx_data_i), .parity_error_i(parity_error_i),
    .host_read_data_o(host_read_data_o), .rts_n_o(rts_n_o), .rx_rd_i(rx_rd_i),
    .rx_flush_i(rx_flush_i), .rx_rdata_o(rx_rdata_o), .rx_perr_o(rx_perr_o),
    .rx_full_o(rx_full_o), .rx_empty_o(rx_empty_o), .rx_level_o(rx_level_o),
    .rx_ovr_o(rx_ovr_o), .err_clr_i(err_clr_i)
  );

  // Small instance for the DEPTH=4 overflow scenario
  logic        s_wr = 0, s_cts_n = 1, s_clr = 0, s_zero = 0;
  logic [7:0]  s_wdata = 0;
  logic [31:0] s_zero32 = 0;
  logic        s_full, s_empty, s_ovf, s_start, s_ack, s_rts, s_perr, s_rfull, s_rempty, s_ovr;
  logic [2:0]  s_level, s_rlevel;
  logic [31:0] s_txd;
  logic [7:0]  s_rdata;

  uart_fifo_ctrl #(.DEPTH(4)) u_small (
    .clk(clk), .rst_n(rst_n), .tx_wr_i(s_wr), .tx_wdata_i(s_wdata),
    .tx_flush_i(s_zero), .tx_full_o(s_full), .tx_empty_o(s_empty),
    .tx_level_o(s_level), .tx_ovf_o(s_ovf), .start_tx_o(s_start),
    .tx_data_o(s_txd), .tx_done_i(s_zero), .cts_n_i(s_cts_n),
    .rx_done_i(s_zero), .rx_data_i(s_zero32), .parity_error_i(s_zero),
    .host_read_data_o(s_ack), .rts_n_o(s_rts), .rx_rd_i(s_zero),
    .rx_flush_i(s_zero), .rx_rdata_o(s_rdata), .rx_perr_o(s_perr),
    .rx_full_o(s_rfull), .rx_empty_o(s_rempty), .rx_level_o(s_rlevel),
    .rx_ovr_o(s_ovr), .err_clr_i(s_clr)
  );

  int n_cmp = 0, n_err = 0, cyc = 0;

  // reference model state
  logic [7:0] txq[$];
  logic [8:0] rxq[$];
  bit         m_busy, m_start, m_ovf, m_ovr, m_cts, m_rxd_prev, m_ack, m_rts;
  logic [7:0] m_txd;
  logic [8:0] m_hold;

  // transmitter responder and start log
  int          resp_cnt = 0, resp_lo = 10, resp_hi = 10;
  bit          resp_en = 1;
  logic [31:0] log_data[$];
  int          log_cyc[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    txq.delete(); rxq.delete();
    m_busy = 0; m_start = 0; m_ovf = 0; m_ovr = 0; m_cts = 1;
    m_rxd_prev = 0; m_ack = 0; m_rts = 0; m_txd = 0; m_hold = 0;
  endtask

  task automatic model_step();
    bit tx_full, rx_full, launch, rx_pop, edge_seen, rts_next;
    tx_full  = (txq.size() == DEPTH);
    rx_full  = (rxq.size() == DEPTH);
    launch   = !m_busy && (txq.size() > 0) && !m_cts;
    if (m_start) m_start = 0;
    else if (m_busy && tx_done_i) m_busy = 0;
    if (launch) begin
      m_txd = txq.pop_front();
      m_busy = 1;
      m_start = 1;
    end
    if (tx_flush_i) txq.delete();
    else if (tx_wr_i && (!tx_full || launch)) txq.push_back(tx_wdata_i);
    if (tx_wr_i && tx_full && !launch && !tx_flush_i) m_ovf = 1;
    else if (err_clr_i) m_ovf = 0;
    m_cts = cts_n_i;

    rts_next   = (rxq.size() >= TH);
    edge_seen  = rx_done_i && !m_rxd_prev;
    m_rxd_prev = rx_done_i;
    m_ack      = edge_seen;
    rx_pop     = rx_rd_i && (rxq.size() > 0);
    if (rxq.size() > 0) m_hold = rxq[0];
    if (edge_seen && rx_full && !rx_pop && !rx_flush_i) m_ovr = 1;
    else if (err_clr_i) m_ovr = 0;
    if (rx_pop) void'(rxq.pop_front());
    if (rx_flush_i) rxq.delete();
    else if (edge_seen && (!rx_full || rx_pop)) rxq.push_back({parity_error_i, rx_data_i[7:0]});
    m_rts = rts_next;
  endtask

  task automatic compare_all();
    logic [8:0] head;
    head = (rxq.size() > 0) ? rxq[0] : m_hold;
    chk("tx_level", 32'(tx_level_o), txq.size());
    chk("tx_full", 32'(tx_full_o), 32'(txq.size() == DEPTH));
    chk("tx_empty", 32'(tx_empty_o), 32'(txq.size() == 0));
    chk("tx_ovf", 32'(tx_ovf_o), 32'(m_ovf));
    chk("start_tx", 32'(start_tx_o), 32'(m_start));
    chk("tx_data", tx_data_o, {24'h0, m_txd});
    chk("host_read_data", 32'(host_read_data_o), 32'(m_ack));
    chk("rts_n", 32'(rts_n_o), 32'(m_rts));
    chk("rx_level", 32'(rx_level_o), rxq.size());
    chk("rx_full", 32'(rx_full_o), 32'(rxq.size() == DEPTH));
    chk("rx_empty", 32'(rx_empty_o), 32'(rxq.size() == 0));
    chk("rx_ovr", 32'(rx_ovr_o), 32'(m_ovr));
    chk("rx_rdata", 32'(rx_rdata_o), 32'(head[7:0]));
    chk("rx_perr", 32'(rx_perr_o), 32'(head[8]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
    cyc++;
    compare_all();
    tx_done_i = 0;
    if (start_tx_o) begin
      log_data.push_back(tx_data_o);
      log_cyc.push_back(cyc);
      resp_cnt = resp_en ? int'($urandom_range(resp_hi, resp_lo)) : 0;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) tx_done_i = 1;
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic tx_push(logic [7:0] d);
    tx_wr_i = 1; tx_wdata_i = d; tick(); tx_wr_i = 0;
  endtask

  task automatic rx_edge(logic [7:0] d, logic p);
    rx_done_i = 1; rx_data_i = {24'hABCDE0, d}; parity_error_i = p;
    tick();
    rx_done_i = 0; parity_error_i = 0;
    tick();
  endtask

  initial begin
    int t0, rd_pct;
    model_reset();
    ticks(3);
    chk("reset_tx_empty", 32'(tx_empty_o), 1);
    chk("reset_rts_n", 32'(rts_n_o), 0);
    chk("reset_rx_rdata", 32'(rx_rdata_o), 0);
    rst_n = 1;
    ticks(2);

    // three frames in order, done returned 10 cycles after each start
    cts_n_i = 0; ticks(2);
    log_data.delete(); log_cyc.delete();
    tx_push(8'h41); tx_push(8'h42); tx_push(8'h43);
    ticks(60);
    chk("seq_starts", log_data.size(), 3);
    for (int k = 0; k < 3 && k < log_data.size(); k++) chk("seq_data", log_data[k], 32'h41 + k);
    for (int k = 1; k < log_cyc.size(); k++) chk("seq_gap_ge3", 32'(log_cyc[k] - log_cyc[k-1] >= 3), 1);

    // clear-to-send held off with two entries queued
    cts_n_i = 1; ticks(2);
    log_data.delete(); log_cyc.delete();
    tx_push(8'h10); tx_push(8'h11);
    ticks(5);
    chk("cts_hold_nostart", log_data.size(), 0);
    chk("cts_hold_level", 32'(tx_level_o), 2);
    cts_n_i = 0; t0 = cyc;
    for (int i = 0; i < 10 && log_cyc.size() == 0; i++) tick();
    chk("cts_release_seen", 32'(log_cyc.size() > 0), 1);
    if (log_cyc.size() > 0) chk("cts_release_lat", log_cyc[0] - t0, 2);
    ticks(40);
    chk("cts_drain_starts", log_data.size(), 2);

    // parity-flagged receive
    rx_done_i = 1; rx_data_i = 32'h55; parity_error_i = 1;
    tick();
    rx_done_i = 0; parity_error_i = 0;
    chk("perr_rdata", 32'(rx_rdata_o), 32'h55);
    chk("perr_flag", 32'(rx_perr_o), 1);
    chk("perr_ack", 32'(host_read_data_o), 1);
    tick();
    chk("perr_ack_once", 32'(host_read_data_o), 0);
    rx_rd_i = 1; tick(); rx_rd_i = 0;
    chk("pop_to_empty", 32'(rx_empty_o), 1);
    chk("empty_holds_rdata", 32'(rx_rdata_o), 32'h55);
    rx_rd_i = 1; tick(); rx_rd_i = 0;
    chk("pop_when_empty", 32'(rx_level_o), 0);

    // RTS threshold and overrun
    for (int i = 0; i < 14; i++) rx_edge(8'h10 + 8'(i), 0);
    chk("rts_at_14", 32'(rts_n_o), 1);
    chk("rx_level_14", 32'(rx_level_o), 14);
    rx_rd_i = 1; tick(); rx_rd_i = 0;
    tick();
    chk("rts_after_pop", 32'(rts_n_o), 0);
    for (int i = 0; i < 3; i++) rx_edge(8'h1E + 8'(i), 0);
    chk("rx_full_16", 32'(rx_full_o), 1);
    rx_edge(8'h21, 0);
    chk("rx_ovr_set", 32'(rx_ovr_o), 1);
    chk("rx_level_held", 32'(rx_level_o), 16);
    for (int i = 0; i < 16; i++) begin
      chk("rx_readout", 32'(rx_rdata_o), 32'h11 + i);
      rx_rd_i = 1; tick(); rx_rd_i = 0;
    end
    err_clr_i = 1; tick(); err_clr_i = 0;
    chk("rx_ovr_clr", 32'(rx_ovr_o), 0);

    // DEPTH=4 overflow on the small instance
    for (int k = 0; k < 5; k++) begin
      s_wr = 1; s_wdata = 8'(k); tick(); s_wr = 0;
    end
    chk("small_full", 32'(s_full), 1);
    chk("small_level", 32'(s_level), 4);
    chk("small_ovf", 32'(s_ovf), 1);
    chk("small_nostart", 32'(s_start), 0);
    s_clr = 1; tick(); s_clr = 0;
    chk("small_ovf_clr", 32'(s_ovf), 0);

    // reset during WAIT_DONE abandons the frame
    resp_en = 0; log_data.delete(); log_cyc.delete();
    tx_push(8'h77);
    for (int i = 0; i < 10 && log_cyc.size() == 0; i++) tick();
    chk("rst_frame_started", log_data.size(), 1);
    ticks(3);
    rst_n = 0; model_reset(); resp_cnt = 0;
    #1;
    compare_all();
    chk("rst_tx_empty", 32'(tx_empty_o), 1);
    chk("rst_tx_data", tx_data_o, 0);
    chk("rst_small_empty", 32'(s_empty), 1);
    ticks(2);
    rst_n = 1;
    log_data.delete(); log_cyc.delete();
    tx_done_i = 1; tick();
    ticks(10);
    chk("rst_no_start", log_data.size(), 0);
    resp_en = 1;
    tx_push(8'h78);
    ticks(5);
    chk("rst_new_start", log_data.size(), 1);
    if (log_data.size() > 0) chk("rst_new_data", log_data[0], 32'h78);
    ticks(20);

    // randomized traffic checked against the model every cycle
    resp_lo = 1; resp_hi = 6; rd_pct = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) rd_pct = (rd_pct == 30) ? 8 : 30;
      tx_wr_i        = ($urandom_range(99) < 35);
      tx_wdata_i     = 8'($urandom);
      tx_flush_i     = ($urandom_range(99) < 2);
      if ($urandom_range(99) < 5) cts_n_i = ~cts_n_i;
      if ($urandom_range(99) < 30) rx_done_i = ~rx_done_i;
      rx_data_i      = $urandom;
      parity_error_i = 1'($urandom);
      rx_rd_i        = ($urandom_range(99) < rd_pct);
      rx_flush_i     = ($urandom_range(99) < 2);
      err_clr_i      = ($urandom_range(99) < 3);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
